// File: rtl/imu_frame_assembler_if.sv
// Handshake bundles around the IMU frame assembler:
// the raw tagged-word stream from the sensor reader and the assembled 6-axis frame to the filter.

interface imu_raw_if #(
    parameter int unsigned RAW_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_axis;
    logic [RAW_WIDTH-1:0] in_data;

    // Sensor reader side
    modport master (
        output in_valid,
        output in_axis,
        output in_data,
        input  in_ready
    );

    // Assembler side
    modport slave (
        input  in_valid,
        input  in_axis,
        input  in_data,
        output in_ready
    );
endinterface

interface imu_frame_if #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned GYRO_WIDTH = 32
);
    logic                  valid_out;
    logic                  ready_out;
    logic [ACC_WIDTH-1:0]  a_x;
    logic [ACC_WIDTH-1:0]  a_y;
    logic [ACC_WIDTH-1:0]  a_z;
    logic [GYRO_WIDTH-1:0] w_x;
    logic [GYRO_WIDTH-1:0] w_y;
    logic [GYRO_WIDTH-1:0] w_z;

    // Assembler side
    modport master (
        output valid_out,
        output a_x,
        output a_y,
        output a_z,
        output w_x,
        output w_y,
        output w_z,
        input  ready_out
    );

    // Filter side
    modport slave (
        input  valid_out,
        input  a_x,
        input  a_y,
        input  a_z,
        input  w_x,
        input  w_y,
        input  w_z,
        output ready_out
    );
endinterface

// File: rtl/imu_frame_assembler.sv
// IMU frame assembler: offset-corrects and scales tagged raw axis words, collects them into
// 6-axis frames and hands complete frames to the filter through a double-buffered output slot.

module imu_frame_assembler #(
    parameter int unsigned RAW_WIDTH      = 16,
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned GYRO_WIDTH     = 32,
    parameter int unsigned ACC_SHIFT      = 0,
    parameter int unsigned GYRO_SHIFT     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    imu_raw_if.slave               raw,
    input  logic [6*RAW_WIDTH-1:0] offset_i,
    imu_frame_if.master            frm,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned DIFF_W = RAW_WIDTH + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]       MASK_FULL = 6'h3F;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [5:0]            r_mask;
    logic [TMO_W-1:0]      r_tmo;
    logic [ACC_WIDTH-1:0]  r_acc     [3];
    logic [GYRO_WIDTH-1:0] r_gyr     [3];
    logic [ACC_WIDTH-1:0]  r_out_acc [3];
    logic [GYRO_WIDTH-1:0] r_out_gyr [3];
    logic                  r_valid;
    logic                  r_err;
    logic [15:0]           r_cnt;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_dup;
    logic                  w_complete;
    logic                  w_slot_free;
    logic                  w_tmo_expire;
    logic                  w_load_new;
    logic                  w_load_pend;
    logic [5:0]            w_onehot;
    logic [5:0]            w_mask_upd;
    logic [RAW_WIDTH-1:0]  w_off;
    logic signed [DIFF_W-1:0] w_diff;
    logic [ACC_WIDTH-1:0]  w_acc_val;
    logic [GYRO_WIDTH-1:0] w_gyr_val;
    logic [ACC_WIDTH-1:0]  w_acc_nxt [3];
    logic [GYRO_WIDTH-1:0] w_gyr_nxt [3];

    assign w_in_ready   = (r_state == ST_COLLECT);
    assign w_accept     = raw.in_valid && w_in_ready;
    assign w_legal      = (raw.in_axis < 3'd6);
    assign w_dup        = w_legal && ((r_mask & w_onehot) != 6'h00);
    assign w_mask_upd   = w_dup ? w_onehot : (r_mask | w_onehot);
    assign w_complete   = w_accept && w_legal && (w_mask_upd == MASK_FULL);
    assign w_slot_free  = !r_valid || frm.ready_out;
    assign w_tmo_expire = (r_state == ST_COLLECT) && !w_accept &&
                          (r_mask != 6'h00) && (r_tmo == TMO_LAST);

    // Decode the axis tag into its mask bit and calibration offset
    always_comb begin
        w_onehot = 6'h00;
        w_off    = '0;
        case (raw.in_axis)
            3'd0: begin w_onehot = 6'b000001; w_off = offset_i[0*RAW_WIDTH +: RAW_WIDTH]; end
            3'd1: begin w_onehot = 6'b000010; w_off = offset_i[1*RAW_WIDTH +: RAW_WIDTH]; end
            3'd2: begin w_onehot = 6'b000100; w_off = offset_i[2*RAW_WIDTH +: RAW_WIDTH]; end
            3'd3: begin w_onehot = 6'b001000; w_off = offset_i[3*RAW_WIDTH +: RAW_WIDTH]; end
            3'd4: begin w_onehot = 6'b010000; w_off = offset_i[4*RAW_WIDTH +: RAW_WIDTH]; end
            3'd5: begin w_onehot = 6'b100000; w_off = offset_i[5*RAW_WIDTH +: RAW_WIDTH]; end
            default: ;
        endcase
    end

    // Offset subtraction in RAW_WIDTH+1 bits (cannot wrap), then sign-extend and align
    always_comb begin
        w_diff    = $signed({raw.in_data[RAW_WIDTH-1], raw.in_data}) -
                    $signed({w_off[RAW_WIDTH-1], w_off});
        w_acc_val = ACC_WIDTH'(w_diff) << ACC_SHIFT;
        w_gyr_val = GYRO_WIDTH'(w_diff) << GYRO_SHIFT;
    end

    // Assembly slots as they will look after this cycle's accepted word
    always_comb begin
        w_acc_nxt = r_acc;
        w_gyr_nxt = r_gyr;
        if (w_accept) begin
            case (raw.in_axis)
                3'd0: w_acc_nxt[0] = w_acc_val;
                3'd1: w_acc_nxt[1] = w_acc_val;
                3'd2: w_acc_nxt[2] = w_acc_val;
                3'd3: w_gyr_nxt[0] = w_gyr_val;
                3'd4: w_gyr_nxt[1] = w_gyr_val;
                3'd5: w_gyr_nxt[2] = w_gyr_val;
                default: ;
            endcase
        end
    end

    // Next state and output-slot load strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load_new  = 1'b0;
        w_load_pend = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_complete) begin
                    if (w_slot_free) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_state_nxt = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frm.ready_out) begin
                    w_load_pend = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Collect mask: a completed frame keeps it full until it moves to the output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= 6'h00;
        end else if (w_load_pend) begin
            r_mask <= 6'h00;
        end else if (w_accept && w_legal) begin
            r_mask <= (w_complete && w_slot_free) ? 6'h00 : w_mask_upd;
        end else if (w_tmo_expire) begin
            r_mask <= 6'h00;
        end
    end

    // Idle counter inside a partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if ((r_state != ST_COLLECT) || w_accept || (r_mask == 6'h00) || w_tmo_expire) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Assembly slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '{default: '0};
            r_gyr <= '{default: '0};
        end else begin
            r_acc <= w_acc_nxt;
            r_gyr <= w_gyr_nxt;
        end
    end

    // Output slot, valid flag and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_acc <= '{default: '0};
            r_out_gyr <= '{default: '0};
            r_valid   <= 1'b0;
            r_cnt     <= 16'h0000;
        end else if (w_load_new) begin
            r_out_acc <= w_acc_nxt;
            r_out_gyr <= w_gyr_nxt;
            r_valid   <= 1'b1;
            r_cnt     <= r_cnt + 16'h0001;
        end else if (w_load_pend) begin
            r_out_acc <= r_acc;
            r_out_gyr <= r_gyr;
            r_valid   <= 1'b1;
            r_cnt     <= r_cnt + 16'h0001;
        end else if (frm.ready_out) begin
            r_valid   <= 1'b0;
        end
    end

    // One-cycle error pulse for dropped words and discarded partial frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_accept && (!w_legal || w_dup)) || w_tmo_expire;
        end
    end

    assign raw.in_ready  = w_in_ready;
    assign frm.valid_out = r_valid;
    assign frm.a_x       = r_out_acc[0];
    assign frm.a_y       = r_out_acc[1];
    assign frm.a_z       = r_out_acc[2];
    assign frm.w_x       = r_out_gyr[0];
    assign frm.w_y       = r_out_gyr[1];
    assign frm.w_z       = r_out_gyr[2];
    assign frame_err     = r_err;
    assign frame_cnt     = r_cnt;

endmodule
